// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle logic/arith/shift ops, WIDTH-step shift-add multiply
// and restoring divide, with a one-cycle done pulse and registered result/flags.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [5:0]           flags
);
    localparam int SHAMT = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH:0]        sum, diff;
    logic [SHAMT-1:0]      shamt;
    logic [WIDTH:0]        shl_t, shr_t;
    logic signed [WIDTH:0] sar_t;
    logic [WIDTH-1:0]      lo;
    logic                  carry, ovf, sc_multi;
    logic [2*WIDTH-1:0]    sc_result;
    logic [5:0]            sc_flags;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHAMT-1:0];
    // One guard bit beside the operand catches the last bit shifted out.
    assign shl_t = {1'b0, a} << shamt;
    assign shr_t = {a, 1'b0} >> shamt;
    assign sar_t = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        lo        = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        sc_multi  = 1'b0;
        sc_result = '0;
        sc_flags  = '0;
        case (op)
            4'd0: begin
                lo    = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1, 4'd10: begin
                lo    = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: lo = a & b;
            4'd3: lo = a | b;
            4'd4: lo = a ^ b;
            4'd5: begin
                lo    = shl_t[WIDTH-1:0];
                carry = shl_t[WIDTH];
            end
            4'd6: begin
                lo    = shr_t[WIDTH:1];
                carry = shr_t[0];
            end
            4'd7: begin
                lo    = sar_t[WIDTH:1];
                carry = sar_t[0];
            end
            4'd8: sc_multi = 1'b1;
            4'd9: sc_multi = (b != '0);
            default: ;
        endcase

        if (op == 4'd9 && b == '0) begin
            sc_result = {a, {WIDTH{1'b1}}};
            sc_flags  = 6'b011000;
        end else if (op > 4'd10) begin
            sc_result = '0;
            sc_flags  = 6'b100000;
        end else begin
            sc_result = (op == 4'd10) ? '0 : {{WIDTH{1'b0}}, lo};
            sc_flags  = {2'b00, lo[WIDTH-1], ovf, carry, (lo == '0)};
        end
    end

    // Iterative step: acc holds {partial product, multiplier} or {remainder, quotient}.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   step_next;
    logic [5:0]           fin_flags;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign rem_ge  = (rem_sh >= {1'b0, opnd});
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd;

    always_comb begin
        if (is_div)
            step_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        else
            step_next = {mul_sum, acc[WIDTH-1:1]};
        fin_flags = {2'b00, step_next[WIDTH-1],
                     (!is_div && (step_next[2*WIDTH-1:WIDTH] != '0)),
                     1'b0, (step_next[WIDTH-1:0] == '0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (sc_multi) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            is_div <= op[0];
                            opnd   <= b;
                            acc    <= {{WIDTH{1'b0}}, a};
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= sc_result;
                            flags  <= sc_flags;
                        end
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= step_next;
                        flags  <= fin_flags;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core (WIDTH=8): transaction-level model checked every cycle,
// directed literal cases, then randomized traffic with occasional resets.
module tb_alu_seq_core;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [3:0]     op = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done;
    logic [2*W-1:0] result;
    logic [5:0]     flags;

    int checks = 0;
    int errors = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {result[15:0], flags[5:0]} from plain integer arithmetic.
    function automatic logic [21:0] ref_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb);
        int ua, ub, sa, sb, sh, r, s;
        bit err, dz, neg, ovf, cy, z;
        ua = xa; ub = xb; r = 0;
        err = 0; dz = 0; ovf = 0; cy = 0;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sh = ub % 8;
        case (o)
            4'd0: begin s = ua + ub; r = s % 256; cy = (s >= 256); ovf = (sa + sb > 127) || (sa + sb < -128); end
            4'd1, 4'd10: begin r = (ua - ub + 256) % 256; cy = (ua < ub); ovf = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin r = (ua << sh) % 256; cy = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1); end
            4'd6: begin r = ua >> sh; cy = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd7: begin r = (sa >>> sh) & 255; cy = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1); end
            4'd8: begin r = ua * ub; ovf = (r > 255); end
            4'd9: begin
                if (ub == 0) begin r = ua * 256 + 255; dz = 1; end
                else r = (ua % ub) * 256 + ua / ub;
            end
            default: return {16'h0000, 6'b100000};
        endcase
        z   = ((r % 256) == 0);
        neg = (((r >> 7) & 1) == 1);
        if (o == 4'd10) r = 0;
        return {16'(r), err, dz, neg, ovf, cy, z};
    endfunction

    logic        m_busy = 0, m_done = 0;
    logic [15:0] m_res = 0, pend_res = 0;
    logic [5:0]  m_flg = 0, pend_flg = 0;
    int          m_cnt = 0;
    logic [21:0] m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_res = 0; m_flg = 0; m_cnt = 0;
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("result", result, m_res);
        chk("flags", flags, m_flg);
        if (!rst) begin
            if (m_busy) begin
                m_cnt--;
                m_done = 0;
                if (m_cnt == 0) begin
                    m_busy = 0; m_done = 1; m_res = pend_res; m_flg = pend_flg;
                end
            end else begin
                m_done = 0;
                if (start) begin
                    m_e = ref_op(op, a, b);
                    if (op == 4'd8 || (op == 4'd9 && b != 0)) begin
                        m_busy = 1; m_cnt = W; pend_res = m_e[21:6]; pend_flg = m_e[5:0];
                    end else begin
                        m_done = 1; m_res = m_e[21:6]; m_flg = m_e[5:0];
                    end
                end
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [15:0] er, input logic [5:0] ef, input int elat, input int ebusy);
        int c, nb;
        c = 1; nb = 0;
        @(posedge clk); #1 start = 1; op = o; a = xa; b = xb;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
            c++;
        end
        chk({name, "_latency"}, c, elat);
        chk({name, "_busy_cycles"}, nb, ebusy);
        chk({name, "_result"}, result, er);
        chk({name, "_flags"}, flags, ef);
    endtask

    initial begin
        int nd, first;
        bit seen;
        @(posedge clk); #1;
        chk("reset_state", {busy, done, result, flags}, 0);
        rst = 0;
        repeat (2) @(posedge clk);

        run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 16'h0000, 6'b000011, 1, 0);
        run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 16'h007F, 6'b000100, 1, 0);
        run_op("cmp_05_05", 4'd10, 8'h05, 8'h05, 16'h0000, 6'b000001, 1, 0);
        run_op("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 16'hFE01, 6'b000100, 9, 8);
        run_op("div_64_07", 4'd9, 8'h64, 8'h07, 16'h020E, 6'b000000, 9, 8);
        run_op("div_2a_00", 4'd9, 8'h2A, 8'h00, 16'h2AFF, 6'b011000, 1, 0);
        run_op("illegal_c", 4'd12, 8'h12, 8'h34, 16'h0000, 6'b100000, 1, 0);
        run_op("sar_81_s1", 4'd7, 8'h81, 8'h01, 16'h00C0, 6'b001010, 1, 0);

        // Back-to-back: ADD issued in the MUL's done cycle.
        @(posedge clk); #1 start = 1; op = 4'd8; a = 8'h10; b = 8'h10;
        @(posedge clk); #1 start = 0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        chk("b2b_mul_done", done, 1);
        chk("b2b_mul_result", result, 16'h0100);
        start = 1; op = 4'd0; a = 8'h05; b = 8'h03;
        @(posedge clk); #1 start = 0;
        chk("b2b_add_done", done, 1);
        chk("b2b_add_result", result, 16'h0008);
        chk("b2b_add_flags", flags, 6'b000000);

        // Start and operand changes during RUN are ignored.
        @(posedge clk); #1 start = 1; op = 4'd8; a = 8'h0D; b = 8'h0B;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 start = 1; op = 4'd0; a = 8'h01; b = 8'h02;
        @(posedge clk); #1 start = 0; op = 4'd9; a = 8'hFF; b = 8'hFF;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("ignore_done_seen", seen, 1);
        chk("ignore_result", result, 16'h008F);
        chk("ignore_flags", flags, 6'b001000);

        // Reset mid-MUL aborts; start in the deassert cycle is taken at the next edge.
        @(posedge clk); #1 start = 1; op = 4'd8; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1 start = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        #1 chk("rst_outputs_zero", {busy, done, result, flags}, 0);
        @(posedge clk); #1 rst = 0; start = 1; op = 4'd0; a = 8'h03; b = 8'h04;
        @(posedge clk); #1 start = 0;
        nd = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (first < 0) first = i;
            end
        end
        chk("rst_done_count", nd, 1);
        chk("rst_first_done_cycle", first, 0);
        chk("rst_add_result", result, 16'h0007);

        // Randomized traffic; the per-cycle model does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 249) == 0);
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'(8 + $urandom_range(0, 1));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 5) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
            if ($urandom_range(0, 7) == 0) a = 8'hFF;
        end
        @(posedge clk); #1 rst = 0; start = 0;
        repeat (12) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; legal values 4..32; SHAMT = clog2(WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  4  opcode, captured with start.
REQ-006 a  input  WIDTH  operand A, captured with start.
REQ-007 b  input  WIDTH  operand B, captured with start.
REQ-008 busy  output  1  high while a multi-cycle op is in progress.
REQ-009 done  output  1  one-cycle pulse; result/flags valid and stable from this cycle until the next done.
REQ-010 result  output  2*WIDTH  result; upper half is zero except for MUL and DIV.
REQ-011 flags  output  6  {err, dz, neg, ovf, carry, zero}, msb first.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR, 8 MUL (unsigned), 9 DIV (unsigned), 10 CMP, 11-15 illegal.
REQ-013 States: IDLE, RUN, DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-014 IDLE, start=1 at edge k, single-cycle op (0-7, 10, 11-15, or DIV with b=0): result/flags registered at edge k, state -> DONE, done=1 for the cycle after edge k.
REQ-015 IDLE, start=1 at edge k, MUL or DIV with b!=0: operands latched, counter loaded with WIDTH, state -> RUN, busy=1.
REQ-016 RUN: one shift-add (MUL) or restoring-subtract (DIV) step per edge; the counter decrements; at the edge where counter reaches 0, state -> DONE, busy=0, done=1; done is first high after edge k+WIDTH.
REQ-017 In DONE, start=1 is accepted exactly as in IDLE (back-to-back issue; no idle bubble required).
REQ-018 start while busy=1 is ignored, with no queuing; a/b/op changes during RUN have no effect.
REQ-019 ADD/SUB: result low half = a+b / a-b mod 2^WIDTH; carry = carry-out (ADD) or borrow, i.e. a<b unsigned (SUB); ovf = signed overflow.
REQ-020 AND/OR/XOR: bitwise; carry=0, ovf=0.
REQ-021 SHL/SHR/SAR: shift a by b[SHAMT-1:0]; carry = last bit shifted out; shift amount 0 gives a unchanged, carry=0; ovf=0.
REQ-022 MUL: result = full 2*WIDTH product; ovf=1 iff the upper half is nonzero; carry=0.
REQ-023 DIV: result = {remainder, quotient}; b=0 gives quotient all-ones, remainder=a, dz=1, single-cycle per REQ-014.
REQ-024 CMP: result=0; zero/carry/ovf/neg are computed from a-b exactly as SUB.
REQ-025 zero = (result[WIDTH-1:0]==0) and neg = result[WIDTH-1] for all ops except CMP; for CMP, both are computed from a-b.
REQ-026 Illegal op: result=0, err=1, all other flags 0, completes as a single-cycle op.
REQ-027 dz and err are 0 unless set by REQ-023/REQ-026; all flags are rewritten at every done.

Reset
REQ-028 rst=1 forces IDLE immediately (asynchronous): busy=0, done=0, result=0, flags=0, counter=0.
REQ-029 rst asserted during RUN aborts the op; no done pulse follows, and the first start after rst deasserts behaves as from IDLE.
REQ-030 start during the cycle rst deasserts is sampled normally at the next rising edge.

Verification (WIDTH=8)
REQ-031 ADD a=0xFF b=0x01 -> done one cycle later; result=0x0000, zero=1, carry=1, ovf=0.
REQ-032 SUB a=0x80 b=0x01 -> result=0x007F, ovf=1, carry=0, neg=0; CMP a=0x05 b=0x05 -> result=0, zero=1.
REQ-033 MUL a=0xFF b=0xFF -> busy high for 8 cycles, done after edge k+8; result=0xFE01, ovf=1.
REQ-034 DIV a=0x64 b=0x07 -> result=0x020E (rem 2, quot 14); DIV a=0x2A b=0x00 -> single-cycle, result=0x2AFF, dz=1.
REQ-035 MUL started, start+ADD pulsed mid-RUN -> ignored, MUL result unchanged; then rst mid-MUL -> no done pulse, all outputs 0.
REQ-036 Back-to-back: ADD started in the DONE cycle of a MUL -> accepted, done one cycle later; op=0xC -> err=1, result=0.
